// File: rtl/laser_pkg.sv
// laser_pkg: shared types and constants for the laser link packetizer.
// The CRC-8 step helper is only referenced when LASER_PKT_CRC8_EN is defined.
package laser_pkg;

  // Frame builder states; each header state names the byte currently presented
  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StSof,
    StLen,
    StFetch,
    StLoad,
    StChecksum
  } state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SOF_BYTE      = 8'h7E;
  localparam logic [7:0] CRC8_POLY     = 8'h07;

  // One byte of CRC-8, MSB first, no reflection
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/laser_checksum8.sv
// laser_checksum8: running 8-bit frame check over payload bytes.
// Build option LASER_PKT_CRC8_EN selects CRC-8 (poly 0x07, init 0); otherwise
// the result is the byte sum mod 256. One byte is absorbed per enabled cycle.
module laser_checksum8
  import laser_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic [7:0] result
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;

  // Next accumulator value for the selected checksum flavour
  always_comb begin
    acc_d = acc_q;
`ifdef LASER_PKT_CRC8_EN
    acc_d = crc8_step(acc_q, data);
`else
    acc_d = acc_q + data;
`endif
  end

  // Accumulator register; clear starts a new frame
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      acc_q <= 8'h00;
    end else if (enable) begin
      acc_q <= acc_d;
    end
  end

  assign result = acc_q;

endmodule

// File: rtl/laser_packetizer.sv
// laser_packetizer: pops host bytes from the FTDI read FIFO and wraps them into
// laser link frames (preamble, SOF, LEN, payload, checksum), one byte at a time
// on a valid/ready stream towards the TX serializer.
// Build option: define LASER_PKT_CRC8_EN to send CRC-8 instead of the byte sum.
module laser_packetizer #(
  parameter int unsigned MAX_PAYLOAD   = 64,
  parameter int unsigned PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = laser_pkg::PREAMBLE_BYTE,
  parameter logic [7:0]  SOF_BYTE      = laser_pkg::SOF_BYTE,
  parameter int unsigned FLUSH_TIMEOUT = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       rdq_empty,
  input  logic [9:0] qsize,
  input  logic [7:0] data_rd,
  output logic       rdreq,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       pkt_done
);

  import laser_pkg::state_e;
  import laser_pkg::StIdle;
  import laser_pkg::StPreamble;
  import laser_pkg::StSof;
  import laser_pkg::StLen;
  import laser_pkg::StFetch;
  import laser_pkg::StLoad;
  import laser_pkg::StChecksum;

  localparam int unsigned   FlushW    = $clog2(FLUSH_TIMEOUT);
  localparam logic [FlushW-1:0] FlushLast = FlushW'(FLUSH_TIMEOUT - 1);
  localparam logic [9:0]    MaxQ      = 10'(MAX_PAYLOAD);
  localparam logic [7:0]    MaxLen    = 8'(MAX_PAYLOAD);
  localparam logic [3:0]    PreLast   = 4'(PREAMBLE_LEN - 1);

  state_e            state_q;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic              pkt_done_q;
  logic [7:0]        len_q;
  logic [7:0]        count_q;
  logic [3:0]        pre_cnt_q;
  logic              cks_sent_q;   // checksum byte (not last payload byte) is on tx_data
  logic [FlushW-1:0] flush_q;

  logic       accept;
  logic       fetch;
  logic       start_full;
  logic       start_flush;
  logic       flush_run;
  logic [7:0] count_inc;
  logic       cks_clear;
  logic       cks_enable;
  logic [7:0] checksum;

  assign accept      = tx_valid_q & tx_ready;
  // The pop may overlap acceptance of the previous byte, giving 2 cycles per
  // payload byte; this needs tx_ready of the current cycle, so it is not registered.
  assign fetch       = (state_q == StFetch) & (~tx_valid_q | tx_ready) & ~rdq_empty;
  assign start_full  = enable & (qsize >= MaxQ);
  assign start_flush = enable & ~rdq_empty & (flush_q == FlushLast);
  assign flush_run   = enable & ~rdq_empty & (qsize < MaxQ);
  assign count_inc   = count_q + 8'd1;
  assign cks_clear   = clear | (state_q == StLen);
  assign cks_enable  = (state_q == StLoad);

  laser_checksum8 u_checksum (
    .clock  (clock),
    .reset  (reset),
    .clear  (cks_clear),
    .enable (cks_enable),
    .data   (data_rd),
    .result (checksum)
  );

  // Frame sequencer with registered stream outputs
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      state_q    <= StIdle;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      pkt_done_q <= 1'b0;
      len_q      <= 8'h00;
      count_q    <= 8'h00;
      pre_cnt_q  <= 4'd0;
      cks_sent_q <= 1'b0;
      flush_q    <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_full || start_flush) begin
            len_q      <= start_full ? MaxLen : qsize[7:0];
            flush_q    <= '0;
            pre_cnt_q  <= 4'd0;
            cks_sent_q <= 1'b0;
            tx_data_q  <= PREAMBLE_BYTE;
            tx_valid_q <= 1'b1;
            state_q    <= StPreamble;
          end else if (flush_run) begin
            if (flush_q != FlushLast) begin
              flush_q <= flush_q + FlushW'(1);
            end
          end else begin
            flush_q <= '0;
          end
        end

        StPreamble: begin
          if (accept) begin
            if (pre_cnt_q == PreLast) begin
              tx_data_q <= SOF_BYTE;
              state_q   <= StSof;
            end else begin
              pre_cnt_q <= pre_cnt_q + 4'd1;
            end
          end
        end

        StSof: begin
          if (accept) begin
            tx_data_q <= len_q;
            state_q   <= StLen;
          end
        end

        StLen: begin
          count_q <= 8'h00;
          if (accept) begin
            tx_valid_q <= 1'b0;
            state_q    <= StFetch;
          end
        end

        StFetch: begin
          // Pending payload byte may drain while the next one is popped
          if (accept) begin
            tx_valid_q <= 1'b0;
          end
          if (fetch) begin
            state_q <= StLoad;
          end
        end

        StLoad: begin
          tx_data_q  <= data_rd;
          tx_valid_q <= 1'b1;
          count_q    <= count_inc;
          state_q    <= (count_inc < len_q) ? StFetch : StChecksum;
        end

        StChecksum: begin
          if (accept) begin
            if (!cks_sent_q) begin
              tx_data_q  <= checksum;
              cks_sent_q <= 1'b1;
            end else begin
              tx_valid_q <= 1'b0;
              cks_sent_q <= 1'b0;
              pkt_done_q <= 1'b1;
              state_q    <= StIdle;
            end
          end
        end

        default: begin
          tx_valid_q <= 1'b0;
          state_q    <= StIdle;
        end
      endcase
    end
  end

  assign rdreq    = fetch;
  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign busy     = (state_q != StIdle);
  assign pkt_done = pkt_done_q;

endmodule

// File: doc/laser_packetizer.md
Name: laser_packetizer

Overview:
Downstream consumer of the FTDI read queue. Pops host bytes from the FTDI interface's read FIFO and wraps them into laser link frames: preamble, SOF, LEN, payload, checksum. Presents frames one byte at a time on a valid/ready stream to the laser TX serializer.

Parameters:
MAX_PAYLOAD, 64, maximum payload bytes per frame (1..255)
PREAMBLE_LEN, 4, number of preamble bytes per frame (1..15)
PREAMBLE_BYTE, 8'h55, preamble byte value
SOF_BYTE, 8'h7E, start-of-frame byte value
FLUSH_TIMEOUT, 1024, idle cycles with a partial FIFO before a short frame is sent (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
clear  in  1  synchronous abort; same effect as reset
enable  in  1  permits starting a new frame; an in-flight frame always completes
rdq_empty  in  1  read FIFO empty
qsize  in  10  read FIFO used words
data_rd  in  8  read FIFO q; valid the cycle after rdreq (non-showahead)
rdreq  out  1  read FIFO pop strobe
tx_data  out  8  frame byte to serializer
tx_valid  out  1  tx_data valid
tx_ready  in  1  serializer accepts byte when tx_valid && tx_ready
busy  out  1  high in any state other than IDLE
pkt_done  out  1  one-cycle pulse when the checksum byte is accepted

Behaviour:
- Reset/clear: state IDLE; tx_valid=0; tx_data=0; rdreq=0; busy=0; pkt_done=0; counters=0. Clear mid-frame abandons the frame immediately; no further bytes are emitted.
- Output register: tx_data/tx_valid are registered. While tx_valid=1 && tx_ready=0, tx_data holds stable. A byte is consumed only on tx_valid && tx_ready.
- IDLE start conditions, evaluated each cycle with enable=1:
  - qsize >= MAX_PAYLOAD: latch len=MAX_PAYLOAD.
  - Otherwise, if !rdq_empty and the flush counter has reached FLUSH_TIMEOUT-1: latch len=qsize[7:0].
  - On either start: go to PREAMBLE.
- Flush counter:
  - Increments in IDLE while enable && !rdq_empty && qsize<MAX_PAYLOAD.
  - Zeroed otherwise and on frame start.
  - Saturates at FLUSH_TIMEOUT-1.
- PREAMBLE: emit PREAMBLE_BYTE PREAMBLE_LEN times, then SOF.
- SOF: emit SOF_BYTE.
- LEN: emit len. Zero the checksum accumulator and the byte counter.
- FETCH: assert rdreq for exactly one cycle. Requires tx_valid=0, or tx_valid && tx_ready this cycle.
- LOAD: capture data_rd into tx_data; tx_valid=1; update checksum; increment the byte counter.
  - After the byte is accepted: go to FETCH if count<len, else CHECKSUM.
- CHECKSUM: emit the checksum byte. On acceptance, pulse pkt_done and return to IDLE.
- Throughput: a payload byte costs 2 cycles plus any backpressure. Header bytes cost 1 cycle each when tx_ready=1.
- No underflow: this block is the only reader, so qsize cannot fall below the remaining len except by clear. rdreq is never asserted while rdq_empty=1 (defensive gating).
- Checksum: 8-bit sum mod 256 over the payload bytes only. The LEN byte is excluded.
- Back-to-back frames: IDLE is re-entered for at least 1 cycle between frames.

Optional Feature:
LASER_PKT_CRC8_EN
- Defined: the checksum byte is CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR) over the payload bytes, computed one byte per LOAD cycle.
- Undefined: the checksum byte is the 8-bit additive sum.
- Frame length and timing are identical in both builds.

Decomposition:
- Package laser_pkg holds:
  - the state enum type (IDLE, PREAMBLE, SOF, LEN, FETCH, LOAD, CHECKSUM);
  - the constants PREAMBLE_BYTE and SOF_BYTE;
  - the CRC8_POLY constant (8'h07).
- Sub-module laser_checksum8: clear/enable/byte in, 8-bit result out. Selects sum or CRC-8 under the macro, so the FSM stays checksum-agnostic.

Test Plan:
- Full frame: FIFO preloaded with 64 bytes 0x00..0x3F, tx_ready=1, enable=1 → exact stream 55 55 55 55 7E 40 00..3F E0 (sum mod 256), then one pkt_done pulse. 64 rdreq pulses total.
- Timeout flush: 3 bytes 01 02 03, FLUSH_TIMEOUT=16 → frame starts exactly 16 cycles after the FIFO goes non-empty. Stream is preamble, 7E 03 01 02 03 06.
- Backpressure: tx_ready toggling 1/0 each cycle plus random 5-cycle stalls → tx_data stable while stalled. The byte sequence matches the no-stall run. rdreq is never issued while a byte is pending unaccepted.
- Clear mid-payload: clear asserted after 10 payload bytes → next cycle tx_valid=0, busy=0, rdreq=0. The next frame starts cleanly with preamble.
- enable=0 with 100 bytes queued → no frame starts and the flush counter stays 0. Dropping enable mid-frame still completes that frame.
- CRC build (LASER_PKT_CRC8_EN): payload "123456789" (31..39), timeout flush → LEN 09 and checksum byte F4.
